// File: rtl/mult_acc_ci_if.sv
// Nios II custom-instruction handshake bundle between the CPU (master) and mult_acc_ci (slave).
// Request: clk_en/start/n/dataa/datab; completion: done/result, plus busy and sticky ovf status.
interface mult_acc_ci_if;
   logic        clk_en;
   logic        start;
   logic [1:0]  n;
   logic [31:0] dataa;
   logic [31:0] datab;
   logic        done;
   logic [31:0] result;
   logic        busy;
   logic        ovf;

   modport master (
      output clk_en, start, n, dataa, datab,
      input  done, result, busy, ovf
   );

   modport slave (
      input  clk_en, start, n, dataa, datab,
      output done, result, busy, ovf
   );
endinterface

// File: rtl/mult_acc_ci.sv
// MUL/MAC/READ/CLEAR custom-instruction front end for an external 32x32 multiplier; done MUL_LATENCY+2 cycles after start for MUL/MAC, 1 for READ/CLEAR.
// No queuing: start while busy is dropped, and clk_en low freezes every register.
module mult_acc_ci #(
   parameter int MUL_LATENCY = 0,
   parameter int CNT_W       = 4
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   mult_acc_ci_if.slave      ci_if,
   output logic [31:0]       o_mul_dataa,
   output logic [31:0]       o_mul_datab,
   input  logic [31:0]       i_mul_result
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(MUL_LATENCY);

   state_t           r_state, w_state_nxt;
   logic             r_mac,   w_mac_nxt;
   logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
   logic [31:0]      r_acc,   w_acc_nxt;
   logic             r_ovf,   w_ovf_nxt;
   logic [31:0]      r_result, w_result_nxt;
   logic             r_done,  w_done_nxt;
   logic [31:0]      r_mul_dataa, w_mul_dataa_nxt;
   logic [31:0]      r_mul_datab, w_mul_datab_nxt;
   logic [32:0]      w_sum;

   // 33-bit sum so the MAC carry-out feeds the sticky overflow flag
   assign w_sum = {1'b0, r_acc} + {1'b0, i_mul_result};

   always_comb begin
      w_state_nxt     = r_state;
      w_mac_nxt       = r_mac;
      w_cnt_nxt       = r_cnt;
      w_acc_nxt       = r_acc;
      w_ovf_nxt       = r_ovf;
      w_result_nxt    = r_result;
      w_done_nxt      = 1'b0;
      w_mul_dataa_nxt = r_mul_dataa;
      w_mul_datab_nxt = r_mul_datab;

      case (r_state)
         S_IDLE: begin
            if (ci_if.start) begin
               w_mac_nxt = (ci_if.n == 2'd1);
               case (ci_if.n)
                  2'd0, 2'd1: begin
                     w_mul_dataa_nxt = ci_if.dataa;
                     w_mul_datab_nxt = ci_if.datab;
                     w_cnt_nxt       = LAT_CNT;
                     w_state_nxt     = S_WAIT;
                  end
                  2'd2: begin
                     w_result_nxt = r_acc;
                     w_done_nxt   = 1'b1;
                     w_state_nxt  = S_DONE;
                  end
                  default: begin
                     w_acc_nxt    = '0;
                     w_ovf_nxt    = 1'b0;
                     w_result_nxt = '0;
                     w_done_nxt   = 1'b1;
                     w_state_nxt  = S_DONE;
                  end
               endcase
            end
         end
         S_WAIT: begin
            if (r_cnt != '0) begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end else begin
               if (r_mac) begin
                  w_acc_nxt    = w_sum[31:0];
                  w_ovf_nxt    = r_ovf | w_sum[32];
                  w_result_nxt = w_sum[31:0];
               end else begin
                  w_acc_nxt    = i_mul_result;
                  w_ovf_nxt    = 1'b0;
                  w_result_nxt = i_mul_result;
               end
               w_done_nxt  = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= S_IDLE;
         r_mac       <= 1'b0;
         r_cnt       <= '0;
         r_acc       <= '0;
         r_ovf       <= 1'b0;
         r_result    <= '0;
         r_done      <= 1'b0;
         r_mul_dataa <= '0;
         r_mul_datab <= '0;
      end else if (ci_if.clk_en) begin
         r_state     <= w_state_nxt;
         r_mac       <= w_mac_nxt;
         r_cnt       <= w_cnt_nxt;
         r_acc       <= w_acc_nxt;
         r_ovf       <= w_ovf_nxt;
         r_result    <= w_result_nxt;
         r_done      <= w_done_nxt;
         r_mul_dataa <= w_mul_dataa_nxt;
         r_mul_datab <= w_mul_datab_nxt;
      end
   end

   assign ci_if.done   = r_done;
   assign ci_if.result = r_result;
   assign ci_if.busy   = (r_state != S_IDLE);
   assign ci_if.ovf    = r_ovf;
   assign o_mul_dataa  = r_mul_dataa;
   assign o_mul_datab  = r_mul_datab;

endmodule
